// File: rtl/melody_seq_if.sv
// Control/write/output bundle for melody_seq.
// Signals:
//   beat_en, start, pause, stop : playback controls (master -> slave)
//   we, waddr[6:0], wdata[4:0]  : song-memory write port (master -> slave)
//   tn[10:0], note[4:0], addr[6:0], playing, done : sequencer status (slave -> master)
interface melody_seq_if;
  logic        beat_en;
  logic        start;
  logic        pause;
  logic        stop;
  logic        we;
  logic [6:0]  waddr;
  logic [4:0]  wdata;
  logic [10:0] tn;
  logic [4:0]  note;
  logic [6:0]  addr;
  logic        playing;
  logic        done;

  modport master (
    output beat_en, start, pause, stop, we, waddr, wdata,
    input  tn, note, addr, playing, done
  );

  modport slave (
    input  beat_en, start, pause, stop, we, waddr, wdata,
    output tn, note, addr, playing, done
  );
endinterface

// File: rtl/melody_seq.sv
// Beat-driven melody sequencer with a 128x5 song RAM.
// Plays entries 0..SONG_LEN-1, one per beat tick; code 31 ends the song early.
// Emits the current note code and the tone preload value for a tone divider.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (song RAM is not cleared)
//   bus : melody_seq_if.slave (controls, RAM write port, status outputs)
// Optional feature: define MELODY_SEQ_AUTOREPEAT_EN to wrap to entry 0 at end of
// song instead of returning to idle.
module melody_seq #(
  parameter int unsigned SONG_LEN = 128
) (
  input logic         clk,
  input logic         rst,
  melody_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

  localparam logic [4:0]  EndCode  = 5'd31;
  localparam logic [10:0] Silent   = 11'h7FF;
  localparam logic [6:0]  LastAddr = 7'(SONG_LEN - 1);

  logic [4:0]  mem [128];

  state_e      state_q;
  logic [6:0]  addr_q;
  logic [4:0]  note_q;
  logic [10:0] tn_q;
  logic        playing_q;
  logic        done_q;

  logic [6:0]  addr_inc;
  logic [4:0]  next_note;
  logic [4:0]  first_note;
  logic        song_end;

  function automatic logic [10:0] note_to_tn(input logic [4:0] code);
    logic [10:0] tn;
    case (code)
      5'd1:    tn = 11'd773;
      5'd2:    tn = 11'd912;
      5'd3:    tn = 11'd1036;
      5'd4:    tn = 11'd1116;
      5'd5:    tn = 11'd1197;
      5'd6:    tn = 11'd1290;
      5'd7:    tn = 11'd1372;
      5'd8:    tn = 11'd1410;
      5'd9:    tn = 11'd1480;
      5'd10:   tn = 11'd1542;
      5'd11:   tn = 11'd1622;
      5'd12:   tn = 11'd1668;
      5'd13:   tn = 11'd1728;
      5'd14:   tn = 11'd1778;
      5'd15:   tn = 11'd1794;
      5'd16:   tn = 11'd1830;
      5'd17:   tn = 11'd1861;
      5'd18:   tn = 11'd1875;
      5'd19:   tn = 11'd1903;
      5'd20:   tn = 11'd1928;
      5'd21:   tn = 11'd1951;
      default: tn = Silent;
    endcase
    return tn;
  endfunction

  assign addr_inc   = addr_q + 7'd1;
  assign next_note  = mem[addr_inc];
  assign first_note = mem[0];
  // Beat on the last playable entry, or the next entry is the end marker.
  assign song_end   = (addr_q == LastAddr) || (next_note == EndCode);

  // Song RAM: writable only while idle so a playing song cannot change under us.
  always_ff @(posedge clk) begin
    if (!rst && bus.we && (state_q == StIdle)) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= 7'd0;
      note_q    <= 5'd0;
      tn_q      <= Silent;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.stop) begin
            addr_q <= 7'd0;
            note_q <= 5'd0;
            tn_q   <= Silent;
          end else if (bus.start) begin
            if (first_note == EndCode) begin
              // Empty song: report completion without playing.
              done_q <= 1'b1;
            end else begin
              state_q   <= StPlay;
              addr_q    <= 7'd0;
              note_q    <= first_note;
              tn_q      <= note_to_tn(first_note);
              playing_q <= 1'b1;
            end
          end
        end

        StPlay: begin
          if (bus.stop) begin
            state_q   <= StIdle;
            addr_q    <= 7'd0;
            note_q    <= 5'd0;
            tn_q      <= Silent;
            playing_q <= 1'b0;
          end else if (bus.start) begin
            // Already playing; start outranks pause/beat, so nothing moves.
          end else if (bus.pause) begin
            state_q   <= StPause;
            tn_q      <= Silent;
            playing_q <= 1'b0;
          end else if (bus.beat_en) begin
            if (song_end) begin
              done_q <= 1'b1;
`ifdef MELODY_SEQ_AUTOREPEAT_EN
              if (first_note == EndCode) begin
                state_q   <= StIdle;
                addr_q    <= 7'd0;
                note_q    <= 5'd0;
                tn_q      <= Silent;
                playing_q <= 1'b0;
              end else begin
                addr_q <= 7'd0;
                note_q <= first_note;
                tn_q   <= note_to_tn(first_note);
              end
`else
              state_q   <= StIdle;
              addr_q    <= 7'd0;
              note_q    <= 5'd0;
              tn_q      <= Silent;
              playing_q <= 1'b0;
`endif
            end else begin
              addr_q <= addr_inc;
              note_q <= next_note;
              tn_q   <= note_to_tn(next_note);
            end
          end
        end

        StPause: begin
          if (bus.stop) begin
            state_q   <= StIdle;
            addr_q    <= 7'd0;
            note_q    <= 5'd0;
            tn_q      <= Silent;
            playing_q <= 1'b0;
          end else if (bus.start) begin
            state_q   <= StPlay;
            tn_q      <= note_to_tn(note_q);
            playing_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= StIdle;
          addr_q    <= 7'd0;
          note_q    <= 5'd0;
          tn_q      <= Silent;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tn      = tn_q;
  assign bus.note    = note_q;
  assign bus.addr    = addr_q;
  assign bus.playing = playing_q;
  assign bus.done    = done_q;

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 SHALL have parameter SONG_LEN, default 128, meaning the number of song entries played (1..128).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port BEAT_EN  input  1  one-cycle beat tick; advances the song by one entry.
REQ-005 SHALL have port START  input  1  start from IDLE, or resume from PAUSE.
REQ-006 SHALL have port PAUSE  input  1  hold the current position while in PLAY.
REQ-007 SHALL have port STOP  input  1  abort playback and return to IDLE.
REQ-008 SHALL have port WE  input  1  song-memory write strobe.
REQ-009 SHALL have port WADDR  input  7  song-memory write address.
REQ-010 SHALL have port WDATA  input  5  note code to write.
REQ-011 SHALL have port TN  output  11  tone preload value for the downstream tone divider.
REQ-012 SHALL have port NOTE  output  5  current note code.
REQ-013 SHALL have port ADDR  output  7  current song position.
REQ-014 SHALL have port PLAYING  output  1  high in PLAY only.
REQ-015 SHALL have port DONE  output  1  one-cycle end-of-song pulse.

Function
REQ-016 SHALL hold a 128x5 song RAM; each entry lasts one beat; codes: 0 rest, 1-21 notes, 22-30 rest, 31 end marker.
REQ-017 SHALL map note codes to TN combinationally from NOTE as follows; the TN output register is loaded in the same edge as NOTE.
- 1-7 -> 773, 912, 1036, 1116, 1197, 1290, 1372
- 8-14 -> 1410, 1480, 1542, 1622, 1668, 1728, 1778
- 15-21 -> 1794, 1830, 1861, 1875, 1903, 1928, 1951
- all other codes -> 11'h7FF (silent)
REQ-018 SHALL implement the states IDLE, PLAY and PAUSE; input priority: STOP > START > PAUSE > BEAT_EN.
REQ-019 SHALL, on START in IDLE, set ADDR=0 and NOTE=mem[0] in the same edge and enter PLAY; TN and NOTE are valid the following cycle.
REQ-020 SHALL, on BEAT_EN in PLAY, set ADDR=ADDR+1 and NOTE=mem[ADDR+1] in a single edge.
REQ-021 SHALL treat the end of song as a BEAT_EN arriving while ADDR==SONG_LEN-1, or while mem[ADDR+1]==31.
REQ-022 SHALL, on START in IDLE with mem[0]==31, stay in IDLE and pulse DONE.
REQ-023 SHALL, on PAUSE in PLAY, enter PAUSE with the following behaviour.
- ADDR and NOTE held.
- TN forced to 11'h7FF.
- BEAT_EN ignored.
REQ-024 SHALL, on START in PAUSE, return to PLAY at the held ADDR and restore TN from NOTE.
REQ-025 SHALL, on STOP in any state, enter IDLE with ADDR=0, NOTE=0 and TN=11'h7FF; STOP together with BEAT_EN or START SHALL result in IDLE.
REQ-026 SHALL write WDATA to mem[WADDR] on WE only in IDLE; writes in PLAY or PAUSE are ignored; WADDR>=SONG_LEN is written but never played.
REQ-027 SHALL drive PLAYING as a registered output equal to (state==PLAY).

Reset
REQ-028 SHALL, while RST is sampled high, set the following, taking priority over all inputs including mid-playback.
- state=IDLE, ADDR=0, NOTE=0, TN=11'h7FF.
- PLAYING=0, DONE=0.
REQ-029 SHALL leave the song RAM contents unchanged by reset.

Configuration
REQ-030 SHALL support macro MELODY_SEQ_AUTOREPEAT_EN; when it is defined, end of song sets ADDR=0 and NOTE=mem[0], pulses DONE and stays in PLAY; if mem[0]==31 at wrap, the block SHALL enter IDLE instead.
REQ-031 SHALL, when MELODY_SEQ_AUTOREPEAT_EN is undefined, respond to end of song by entering IDLE with ADDR=0, NOTE=0, TN=11'h7FF and a one-cycle DONE pulse.

Verification
REQ-032 SHALL cover: write mem[0..2]=1,8,15, mem[3]=31, START -> TN=773; after BEAT_EN -> 1410; after BEAT_EN -> 1794; after the next BEAT_EN -> DONE one cycle, TN=0x7FF, PLAYING=0 (no autorepeat).
REQ-033 SHALL cover: same song with MELODY_SEQ_AUTOREPEAT_EN defined -> after the 3rd BEAT_EN, ADDR=0, TN=773, DONE pulses once, PLAYING stays 1.
REQ-034 SHALL cover: PAUSE at ADDR=1, then 3 BEAT_EN ticks, then START -> TN=0x7FF while paused, ADDR stays 1, TN=1410 after resume.
REQ-035 SHALL cover: STOP and BEAT_EN in the same cycle at ADDR=2 -> IDLE, ADDR=0, NOTE=0, TN=0x7FF.
REQ-036 SHALL cover: WE with WADDR=0 and WDATA=5 during PLAY -> mem[0] unchanged; after STOP and START -> TN=773.
REQ-037 SHALL cover: RST asserted mid-play at ADDR=5 -> next cycle ADDR=0, TN=0x7FF, PLAYING=0; song RAM contents retained.
